dram_controller: RTL

DRAM_CONTROLLER -- requirements
Module: dram_controller

---
 rtl/dram_controller.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_controller.sv
// ---------------------------------------------------------------------------
// dram_controller
//
// Single-request, open-page controller for a simple SDRAM-like device.
// It accepts one read or write at a time and sequences the DRAM commands:
// PRE, ACT and RD/WR. Each command lasts one cycle. Each command is followed
// by a wait state whose length is set by a parameter.
//
// Handshake rules:
//   * A request transfers on a rising edge where req_valid && req_ready.
//   * req_ready is high only in IDLE while no response is being presented.
//   * rsp_valid is a one-cycle pulse with no backpressure. rsp_rdata and
//     rsp_err are only meaningful in that cycle and read as 0 otherwise.
//
// Ports:
//   dram_clk, dram_rst        sole clock; synchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_we, req_addr,         request fields; addr row = [20:10],
//   req_wstrb, req_wdata      col = [9:0]
//   rsp_valid, rsp_rdata,     completion pulse, read data, read-timeout flag
//   rsp_err
//   DRAM_CSn/RASn/CASn        active-low command strobes
//   DRAM_WEn[3:0]             per-byte active-low write enables
//   DRAM_A[10:0], DRAM_D      address (row or {1'b0,col}) and write data
//   DRAM_Q, DRAM_valid        read data and its qualifier
//   dbg_state                 current FSM state (for observation only)
// ---------------------------------------------------------------------------
module dram_controller #(
  parameter int T_RCD = 5,   // ACT to RD/WR wait cycles, 1..15
  parameter int T_RP  = 5,   // PRE to ACT wait cycles, 1..15
  parameter int T_WR  = 5,   // WR to response wait cycles, 1..15
  parameter int T_TO  = 15   // max RD_W cycles without DRAM_valid, 1..63
) (
  input  logic        dram_clk,
  input  logic        dram_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [20:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PRE   = 4'd1,
    S_PRE_W = 4'd2,
    S_ACT   = 4'd3,
    S_ACT_W = 4'd4,
    S_RD    = 4'd5,
    S_RD_W  = 4'd6,
    S_WR    = 4'd7,
    S_WR_W  = 4'd8
  } state_t;

  localparam logic [5:0] CNT_RCD = 6'(T_RCD);
  localparam logic [5:0] CNT_RP  = 6'(T_RP);
  localparam logic [5:0] CNT_WR  = 6'(T_WR);
  localparam logic [5:0] CNT_TO  = 6'(T_TO);

  // State and bookkeeping
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        row_open_q, row_open_d;
  logic [10:0] open_row_q, open_row_d;

  // Request fields captured at accept
  logic        we_q, we_d;
  logic [10:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  // Registered response
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        last_wait;
  logic [10:0] req_row;

  assign req_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;
  assign req_row   = req_addr[20:10];

  // A wait state ends in the cycle its counter reads 1. A count of 0 is
  // treated the same way, so the counter never wraps.
  assign last_wait = (cnt_q <= 6'd1);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      row_open_q  <= 1'b0;
      open_row_q  <= 11'd0;
      we_q        <= 1'b0;
      row_q       <= 11'd0;
      col_q       <= 10'd0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_open_q  <= row_open_d;
      open_row_q  <= open_row_d;
      we_q        <= we_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, counters, row tracking and response generation
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_open_d  = row_open_q;
    open_row_d  = open_row_q;
    we_d        = we_q;
    row_d       = row_q;
    col_d       = col_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          row_d   = req_row;
          col_d   = req_addr[9:0];
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          if (req_we && (req_wstrb == 4'h0)) begin
            // A write with no byte enabled touches nothing in the DRAM.
            // Complete it at once and leave the page state unchanged.
            rsp_valid_d = 1'b1;
          end else if (row_open_q && (open_row_q == req_row)) begin
            state_d = req_we ? S_WR : S_RD;
            cnt_d   = req_we ? CNT_WR : CNT_TO;
          end else if (row_open_q) begin
            state_d = S_PRE;
            cnt_d   = CNT_RP;
          end else begin
            state_d = S_ACT;
            cnt_d   = CNT_RCD;
          end
        end
      end

      S_PRE: begin
        row_open_d = 1'b0;
        state_d    = S_PRE_W;
      end

      S_PRE_W: begin
        if (last_wait) begin
          state_d = S_ACT;
          cnt_d   = CNT_RCD;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_ACT: begin
        row_open_d = 1'b1;
        open_row_d = row_q;
        state_d    = S_ACT_W;
      end

      S_ACT_W: begin
        if (last_wait) begin
          state_d = we_q ? S_WR : S_RD;
          cnt_d   = we_q ? CNT_WR : CNT_TO;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_RD: begin
        state_d = S_RD_W;
      end

      S_RD_W: begin
        // Data arriving in the final wait cycle still counts as a good read.
        if (DRAM_valid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = DRAM_Q;
          state_d     = S_IDLE;
          cnt_d       = 6'd0;
        end else if (last_wait) begin
          // The device did not answer, so its page state is unknown.
          // Force an ACT on the next access.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          row_open_d  = 1'b0;
          state_d     = S_IDLE;
          cnt_d       = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_WR: begin
        state_d = S_WR_W;
      end

      S_WR_W: begin
        if (last_wait) begin
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // DRAM command bus, decoded from the current state
  // -------------------------------------------------------------------------
  always_comb begin
    DRAM_CSn  = 1'b1;
    DRAM_RASn = 1'b1;
    DRAM_CASn = 1'b1;
    DRAM_WEn  = 4'hF;
    DRAM_A    = 11'd0;
    DRAM_D    = 32'd0;

    unique case (state_q)
      S_PRE: begin
        DRAM_CSn  = 1'b0;
        DRAM_RASn = 1'b0;
        DRAM_WEn  = 4'h0;
      end
      S_ACT: begin
        DRAM_CSn  = 1'b0;
        DRAM_RASn = 1'b0;
        DRAM_A    = row_q;
      end
      S_RD: begin
        DRAM_CSn  = 1'b0;
        DRAM_CASn = 1'b0;
        DRAM_A    = {1'b0, col_q};
      end
      S_WR: begin
        DRAM_CSn  = 1'b0;
        DRAM_CASn = 1'b0;
        DRAM_WEn  = ~wstrb_q;
        DRAM_A    = {1'b0, col_q};
        DRAM_D    = wdata_q;
      end
      default: begin
      end
    endcase
  end

endmodule
